// File: rtl/led_pwm_dimmer_mmio.sv
// -----------------------------------------------------------------------------
// led_pwm_dimmer_mmio
//
// Purpose:
//   LED output stage placed after the four-channel blinker. Each channel's
//   blink bit (led_in) is gated by an 8-bit PWM brightness. The brightness
//   follows a target duty through a linear fade engine. An enable bit and an
//   output-inversion bit are applied before the output register. The block is
//   configured through the blinker's MMIO write slot and has no read path.
//   After reset led_out follows led_in with one clock of delay.
//
// Optional build macro:
//   LED_DIMMER_GAMMA_EN - when defined, the PWM compares against a gamma-
//   corrected duty, (cur*cur)>>8, with 255 passed through unchanged. When it
//   is undefined, the PWM compares against the current duty directly.
//
// Parameters:
//   CLK_DIV - clocks per PWM tick, legal range 1..65535
//   DUTY_W  - duty and PWM counter width, fixed at 8
//
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   cs       in   slot select
//   wr_en    in   write strobe, only honoured while cs is high
//   address  in   [3:2] channel, [1:0] register
//                 reg 0: target duty; reg 1: bit0 enable, bit1 invert
//                 reg 2: fade rate; reg 3: reserved
//   wr_data  in   16-bit write data
//   led_in   in   4-bit blink pattern from the blinker
//   led_out  out  4-bit registered LED drive
// -----------------------------------------------------------------------------
module led_pwm_dimmer_mmio #(
   parameter int unsigned CLK_DIV = 100,
   parameter int unsigned DUTY_W  = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        wr_en,
   input  logic [3:0]  address,
   input  logic [15:0] wr_data,
   input  logic [3:0]  led_in,
   output logic [3:0]  led_out
);

   localparam logic [DUTY_W-1:0] DUTY_MAX = {DUTY_W{1'b1}};
   localparam logic [15:0]       DIV_LAST = 16'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      RAMP_UP   = 2'd1,
      RAMP_DOWN = 2'd2
   } fade_state_t;

   logic [15:0]       presc;
   logic              tick;
   logic [DUTY_W-1:0] pwm_cnt;

   logic [DUTY_W-1:0] target   [4];
   logic [DUTY_W-1:0] cur_duty [4];
   logic [3:0]        enable;
   logic [3:0]        invert;
   logic [15:0]       rate     [4];
   logic [15:0]       fade_tmr [4];

   fade_state_t       fade_state [4];
   logic [DUTY_W-1:0] cur_nxt    [4];
   logic [15:0]       tmr_nxt    [4];
   logic [DUTY_W-1:0] eff_duty   [4];
   logic [3:0]        pwm_on;

   logic              wr_acc;
   logic [1:0]        wr_ch;
   logic [1:0]        wr_reg;

`ifdef LED_DIMMER_GAMMA_EN
   logic [2*DUTY_W-1:0] gamma_sq [4];
`endif

   // One duty step toward the target, saturating at both ends of the range.
   function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                     input logic              up);
      logic [DUTY_W-1:0] res;
      res = cur;
      if (up) begin
         if (cur != DUTY_MAX) res = cur + DUTY_W'(1);
      end else begin
         if (cur != '0) res = cur - DUTY_W'(1);
      end
      return res;
   endfunction

   assign wr_acc = cs & wr_en;
   assign wr_ch  = address[3:2];
   assign wr_reg = address[1:0];
   assign tick   = (presc == DIV_LAST);

   // Fade engine: the state is not stored separately but re-derived every
   // cycle from cur_duty against target, so a target write takes effect in
   // the direction on the very next cycle while the timer keeps running.
   always_comb begin
      for (int c = 0; c < 4; c++) begin
         fade_state[c] = IDLE;
         cur_nxt[c]    = cur_duty[c];
         tmr_nxt[c]    = fade_tmr[c];
         if (cur_duty[c] < target[c])      fade_state[c] = RAMP_UP;
         else if (cur_duty[c] > target[c]) fade_state[c] = RAMP_DOWN;

         case (fade_state[c])
            IDLE: tmr_nxt[c] = '0;
            RAMP_UP, RAMP_DOWN: begin
               if (rate[c] == 16'd0) begin
                  cur_nxt[c] = target[c];
                  tmr_nxt[c] = '0;
               end else if (tick) begin
                  // >= guards against a timer left above a shrunken rate.
                  if (fade_tmr[c] >= rate[c] - 16'd1) begin
                     cur_nxt[c] = step_toward(cur_duty[c], fade_state[c] == RAMP_UP);
                     tmr_nxt[c] = '0;
                  end else begin
                     tmr_nxt[c] = fade_tmr[c] + 16'd1;
                  end
               end
            end
            default: tmr_nxt[c] = '0;
         endcase

         if (wr_acc && (wr_ch == 2'(c)) && (wr_reg == 2'd2)) tmr_nxt[c] = '0;
      end
   end

   // Effective duty and PWM compare.
   always_comb begin
      for (int c = 0; c < 4; c++) begin
`ifdef LED_DIMMER_GAMMA_EN
         gamma_sq[c] = (2*DUTY_W)'(cur_duty[c]) * (2*DUTY_W)'(cur_duty[c]);
         eff_duty[c] = (cur_duty[c] == DUTY_MAX) ? DUTY_MAX
                                                 : gamma_sq[c][2*DUTY_W-1:DUTY_W];
`else
         eff_duty[c] = cur_duty[c];
`endif
         pwm_on[c] = (eff_duty[c] == DUTY_MAX) || (pwm_cnt < eff_duty[c]);
      end
   end

   // Register stage: timebase, configuration, fade state and LED drive.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc   <= '0;
         pwm_cnt <= '0;
         enable  <= '1;
         invert  <= '0;
         led_out <= '0;
         for (int c = 0; c < 4; c++) begin
            target[c]   <= DUTY_MAX;
            cur_duty[c] <= DUTY_MAX;
            rate[c]     <= '0;
            fade_tmr[c] <= '0;
         end
      end else begin
         presc <= tick ? 16'd0 : presc + 16'd1;
         if (tick) pwm_cnt <= pwm_cnt + DUTY_W'(1);

         for (int c = 0; c < 4; c++) begin
            cur_duty[c] <= cur_nxt[c];
            fade_tmr[c] <= tmr_nxt[c];
         end

         if (wr_acc) begin
            case (wr_reg)
               2'd0: target[wr_ch] <= wr_data[DUTY_W-1:0];
               2'd1: begin
                  enable[wr_ch] <= wr_data[0];
                  invert[wr_ch] <= wr_data[1];
               end
               2'd2: rate[wr_ch] <= wr_data;
               default: ;
            endcase
         end

         led_out <= invert ^ (enable & led_in & pwm_on);
      end
   end

endmodule
